// File: rtl/vna_stream_pkg.sv
// Shared layout of the measurement stream: word offsets inside a channel,
// stream width and receiver state encoding. The packetiser uses the same package.
package vna_stream_pkg;

    localparam int STREAM_W     = 32;
    localparam int WORDS_PER_CH = 3;
    localparam int W_VAL_LO     = 0;
    localparam int W_VAL_HI     = 1;
    localparam int W_CNT        = 2;

    typedef enum logic {
        RECV  = 1'b0,
        DRAIN = 1'b1
    } rx_state_e;

endpackage

// File: rtl/depacketiser.sv
// AXI-Stream slave that rebuilds fixed-length measurement packets into
// per-channel value/count results, with framing-error detection.
module depacketiser
    import vna_stream_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int ERR_W  = 16
) (
    input  logic                  aclk,
    input  logic                  rst,
    input  logic [STREAM_W-1:0]   S_AXIS_IN_tdata,
    input  logic                  S_AXIS_IN_tvalid,
    output logic                  S_AXIS_IN_tready,
    input  logic                  S_AXIS_IN_tlast,
    output logic [NUM_CH*64-1:0]  out_val,
    output logic [NUM_CH*32-1:0]  out_cnt,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  err_short,
    output logic                  err_long,
    output logic [ERR_W-1:0]      err_count,
    output logic [31:0]           pkt_count
);

    localparam int WPP   = WORDS_PER_CH * NUM_CH;
    localparam int IDX_W = $clog2(WPP);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WPP - 1);

    function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] c);
        return (c == {ERR_W{1'b1}}) ? c : c + 1'b1;
    endfunction

    rx_state_e              state_q, state_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [STREAM_W-1:0]    shadow_q [0:WPP-2];
    logic [STREAM_W-1:0]    shadow_d [0:WPP-2];
    logic [STREAM_W-1:0]    words    [0:WPP-1];
    logic [NUM_CH*64-1:0]   out_val_q, out_val_d;
    logic [NUM_CH*32-1:0]   out_cnt_q, out_cnt_d;
    logic                   out_valid_q, out_valid_d;
    logic                   err_short_q, err_short_d;
    logic                   err_long_q, err_long_d;
    logic [ERR_W-1:0]       err_count_q, err_count_d;
    logic [31:0]            pkt_count_q, pkt_count_d;
    logic                   tready;
    logic                   accept;

    // Only a pending final word with an unconsumed result can stall the stream.
    assign tready = rst && !(state_q == RECV && idx_q == LAST_IDX && out_valid_q && !out_ready);
    assign accept = S_AXIS_IN_tvalid && tready;

    always_comb begin
        for (int i = 0; i < WPP - 1; i++) begin
            words[i] = shadow_q[i];
        end
        words[WPP-1] = S_AXIS_IN_tdata;
    end

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        shadow_d    = shadow_q;
        out_val_d   = out_val_q;
        out_cnt_d   = out_cnt_q;
        out_valid_d = out_valid_q;
        err_short_d = 1'b0;
        err_long_d  = 1'b0;
        err_count_d = err_count_q;
        pkt_count_d = pkt_count_q;

        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end

        if (accept) begin
            case (state_q)
                RECV: begin
                    if (idx_q != LAST_IDX) begin
                        if (S_AXIS_IN_tlast) begin
                            idx_d       = '0;
                            err_short_d = 1'b1;
                        end else begin
                            shadow_d[idx_q] = S_AXIS_IN_tdata;
                            idx_d           = idx_q + 1'b1;
                        end
                    end else begin
                        idx_d = '0;
                        if (S_AXIS_IN_tlast) begin
                            for (int k = 0; k < NUM_CH; k++) begin
                                out_val_d[64*k +: 64] = {words[WORDS_PER_CH*k + W_VAL_HI],
                                                         words[WORDS_PER_CH*k + W_VAL_LO]};
                                out_cnt_d[32*k +: 32] = words[WORDS_PER_CH*k + W_CNT];
                            end
                            // A commit overrides a same-cycle consume.
                            out_valid_d = 1'b1;
                            pkt_count_d = pkt_count_q + 32'd1;
                        end else begin
                            err_long_d = 1'b1;
                            state_d    = DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (S_AXIS_IN_tlast) begin
                        state_d = RECV;
                        idx_d   = '0;
                    end
                end
                default: begin
                    state_d = RECV;
                    idx_d   = '0;
                end
            endcase
        end

        if (err_short_d || err_long_d) begin
            err_count_d = sat_inc(err_count_q);
        end
    end

    always_ff @(posedge aclk) begin
        if (!rst) begin
            state_q     <= RECV;
            idx_q       <= '0;
            for (int i = 0; i < WPP - 1; i++) begin
                shadow_q[i] <= '0;
            end
            out_val_q   <= '0;
            out_cnt_q   <= '0;
            out_valid_q <= 1'b0;
            err_short_q <= 1'b0;
            err_long_q  <= 1'b0;
            err_count_q <= '0;
            pkt_count_q <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            shadow_q    <= shadow_d;
            out_val_q   <= out_val_d;
            out_cnt_q   <= out_cnt_d;
            out_valid_q <= out_valid_d;
            err_short_q <= err_short_d;
            err_long_q  <= err_long_d;
            err_count_q <= err_count_d;
            pkt_count_q <= pkt_count_d;
        end
    end

    assign S_AXIS_IN_tready = tready;
    assign out_val          = out_val_q;
    assign out_cnt          = out_cnt_q;
    assign out_valid        = out_valid_q;
    assign err_short        = err_short_q;
    assign err_long         = err_long_q;
    assign err_count        = err_count_q;
    assign pkt_count        = pkt_count_q;

endmodule

// File: tb/tb_depacketiser.sv
// Scoreboard bench for depacketiser: expected results are queued as packets are
// driven and compared whenever the consumer accepts a result.
module tb_depacketiser;

    localparam int NUM_CH = 4;
    localparam int ERR_W  = 16;
    localparam int WPP    = 3 * NUM_CH;

    logic                  aclk = 1'b0;
    logic                  rst;
    logic [31:0]           tdata;
    logic                  tvalid;
    logic                  tready;
    logic                  tlast;
    logic [NUM_CH*64-1:0]  out_val;
    logic [NUM_CH*32-1:0]  out_cnt;
    logic                  out_valid;
    logic                  out_ready;
    logic                  err_short;
    logic                  err_long;
    logic [ERR_W-1:0]      err_count;
    logic [31:0]           pkt_count;

    typedef struct {
        logic [255:0] val;
        logic [127:0] cnt;
        logic [31:0]  pc;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] pkt_w [0:WPP-1];
    int          checks   = 0;
    int          failures = 0;
    int          exp_pkt  = 0;
    int          exp_err  = 0;

    always #5 aclk = ~aclk;

    depacketiser #(.NUM_CH(NUM_CH), .ERR_W(ERR_W)) dut (
        .aclk             (aclk),
        .rst              (rst),
        .S_AXIS_IN_tdata  (tdata),
        .S_AXIS_IN_tvalid (tvalid),
        .S_AXIS_IN_tready (tready),
        .S_AXIS_IN_tlast  (tlast),
        .out_val          (out_val),
        .out_cnt          (out_cnt),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .err_short        (err_short),
        .err_long         (err_long),
        .err_count        (err_count),
        .pkt_count        (pkt_count)
    );

    task automatic check_eq(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        tvalid = 1'b0;
        @(posedge aclk);
        #1;
    endtask

    // Holds the beat until it is accepted; returns 1 ns after the accepting edge.
    task automatic send_beat(input logic [31:0] d, input logic last);
        logic acc;
        int   n;
        n      = 0;
        tdata  = d;
        tlast  = last;
        tvalid = 1'b1;
        forever begin
            @(negedge aclk);
            acc = tready;
            @(posedge aclk);
            #1;
            if (acc) break;
            n++;
            if (n > 200) begin
                check_eq("beat_accept_timeout", 256'(0), 256'(1));
                break;
            end
        end
        tvalid = 1'b0;
        tlast  = 1'b0;
    endtask

    task automatic fill_pkt();
        for (int i = 0; i < WPP; i++) pkt_w[i] = $urandom;
    endtask

    task automatic push_expected();
        exp_t e;
        e.val = '0;
        e.cnt = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            e.val[64*k +: 64] = {pkt_w[3*k+1], pkt_w[3*k]};
            e.cnt[32*k +: 32] = pkt_w[3*k+2];
        end
        exp_pkt++;
        e.pc = 32'(exp_pkt);
        exp_q.push_back(e);
    endtask

    task automatic send_good(input bit gaps);
        for (int i = 0; i < WPP; i++) begin
            if (gaps) begin
                for (int g = 0; g < 4 && $urandom_range(1, 0) == 1; g++) idle();
            end
            if (i == WPP - 1) push_expected();
            send_beat(pkt_w[i], i == WPP - 1);
        end
    endtask

    always @(negedge aclk) begin
        exp_t e;
        if (rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check_eq("unexpected_result", 256'(1), 256'(0));
            end else begin
                e = exp_q.pop_front();
                check_eq("out_val", out_val, e.val);
                check_eq("out_cnt", 256'(out_cnt), 256'(e.cnt));
                check_eq("pkt_count_at_result", 256'(pkt_count), 256'(e.pc));
            end
        end
    end

    initial begin
        rst       = 1'b0;
        tdata     = '0;
        tvalid    = 1'b0;
        tlast     = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(posedge aclk);
        #1;
        @(negedge aclk);
        check_eq("reset_tready", 256'(tready), 256'(0));
        check_eq("reset_out_valid", 256'(out_valid), 256'(0));
        check_eq("reset_pkt_count", 256'(pkt_count), 256'(0));
        check_eq("reset_err_count", 256'(err_count), 256'(0));
        check_eq("reset_out_val", out_val, 256'(0));
        @(posedge aclk);
        #1;
        rst = 1'b1;

        // Nominal packet with the reference word pattern.
        pkt_w[0] = 32'd2;
        pkt_w[1] = 32'd1;
        for (int i = 2; i < WPP; i++) pkt_w[i] = 32'(i + 1);
        send_good(1'b0);
        check_eq("nominal_valid_latency", 256'(out_valid), 256'(1));
        check_eq("nominal_val0", 256'(out_val[63:0]), 256'(64'h0000000100000002));
        check_eq("nominal_cnt3", 256'(out_cnt[127:96]), 256'(12));
        check_eq("nominal_pkt_count", 256'(pkt_count), 256'(1));
        idle();
        idle();

        // Backpressure: two packets while the consumer stalls.
        out_ready = 1'b0;
        fill_pkt();
        send_good(1'b0);
        fill_pkt();
        for (int i = 0; i < WPP - 1; i++) send_beat(pkt_w[i], 1'b0);
        push_expected();
        tdata  = pkt_w[WPP-1];
        tlast  = 1'b1;
        tvalid = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge aclk);
            check_eq("bp_tready_low", 256'(tready), 256'(0));
            check_eq("bp_pkt_count_hold", 256'(pkt_count), 256'(exp_pkt - 1));
        end
        @(posedge aclk);
        #1;
        out_ready = 1'b1;
        send_beat(pkt_w[WPP-1], 1'b1);
        check_eq("bp_valid_kept", 256'(out_valid), 256'(1));
        check_eq("bp_pkt_count", 256'(pkt_count), 256'(exp_pkt));
        idle();
        idle();

        // Short packet: tlast on beat 5.
        fill_pkt();
        for (int i = 0; i < 6; i++) send_beat(pkt_w[i], i == 5);
        exp_err++;
        check_eq("short_err_pulse", 256'(err_short), 256'(1));
        check_eq("short_err_count", 256'(err_count), 256'(exp_err));
        check_eq("short_no_long", 256'(err_long), 256'(0));
        idle();
        check_eq("short_pulse_end", 256'(err_short), 256'(0));
        check_eq("short_pkt_hold", 256'(pkt_count), 256'(exp_pkt));
        check_eq("short_no_valid", 256'(out_valid), 256'(0));
        fill_pkt();
        send_good(1'b0);
        idle();

        // Long packet: 15 beats, tlast only on the last.
        fill_pkt();
        for (int i = 0; i < WPP; i++) send_beat(pkt_w[i], 1'b0);
        exp_err++;
        check_eq("long_err_pulse", 256'(err_long), 256'(1));
        check_eq("long_err_count", 256'(err_count), 256'(exp_err));
        for (int i = 0; i < 3; i++) begin
            send_beat(32'hDEAD_0000 + 32'(i), i == 2);
            check_eq("drain_no_pulse", 256'({err_long, err_short}), 256'(0));
        end
        check_eq("long_pkt_hold", 256'(pkt_count), 256'(exp_pkt));
        check_eq("long_err_hold", 256'(err_count), 256'(exp_err));
        fill_pkt();
        send_good(1'b0);
        idle();

        // Random tvalid gaps.
        for (int p = 0; p < 3; p++) begin
            fill_pkt();
            send_good(1'b1);
        end
        idle();
        idle();

        // Reset during beat 7.
        fill_pkt();
        for (int i = 0; i < 7; i++) send_beat(pkt_w[i], 1'b0);
        tdata  = pkt_w[7];
        tvalid = 1'b1;
        rst    = 1'b0;
        @(negedge aclk);
        check_eq("midrst_tready", 256'(tready), 256'(0));
        @(posedge aclk);
        #1;
        check_eq("midrst_pkt_count", 256'(pkt_count), 256'(0));
        check_eq("midrst_err_count", 256'(err_count), 256'(0));
        check_eq("midrst_out_valid", 256'(out_valid), 256'(0));
        check_eq("midrst_out_val", out_val, 256'(0));
        check_eq("midrst_out_cnt", 256'(out_cnt), 256'(0));
        tvalid  = 1'b0;
        rst     = 1'b1;
        exp_pkt = 0;
        exp_err = 0;
        fill_pkt();
        send_good(1'b0);
        check_eq("midrst_commit_pc", 256'(pkt_count), 256'(1));
        repeat (4) idle();

        check_eq("scoreboard_empty", 256'(exp_q.size()), 256'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/depacketiser.md
Name: depacketiser

Overview:
- AXI-Stream slave that reassembles fixed-length measurement packets into parallel per-channel value/count results.
- Each packet carries NUM_CH channels, 3 x 32-bit words per channel: value low half, value high half, count. TLAST marks the final word.
- Sits on the receive side of the measurement stream, e.g. after a DMA MM2S or loopback path.
- Presents the last good packet on registered outputs with a valid/ready handshake and reports framing errors.

Parameters:
- NUM_CH, 4, number of channels per packet; packet length WPP = 3*NUM_CH words (12 at default).
- ERR_W, 16, width of the saturating framing-error counter.

Ports:
- aclk  in  1  clock
- rst  in  1  reset, synchronous, active-low
- S_AXIS_IN_tdata  in  32  stream data word
- S_AXIS_IN_tvalid  in  1  stream valid
- S_AXIS_IN_tready  out  1  stream ready
- S_AXIS_IN_tlast  in  1  end-of-packet marker
- out_val  out  NUM_CH*64  channel k value at bits [64k+63:64k]
- out_cnt  out  NUM_CH*32  channel k count at bits [32k+31:32k]
- out_valid  out  1  result available
- out_ready  in  1  consumer accepts result
- err_short  out  1  one-cycle pulse: TLAST arrived before word WPP-1
- err_long  out  1  one-cycle pulse: word WPP-1 arrived without TLAST
- err_count  out  ERR_W  saturating total of err_short plus err_long events
- pkt_count  out  32  good packets committed, wraps at 2^32

Behaviour:
- Reset (rst=0 at a clock edge): all outputs 0, including tready. Word index = 0, state = RECV, shadow registers = 0. The first beat can be accepted on the first edge after rst returns to 1.
- Beat acceptance: a beat is accepted only when tvalid && tready at a rising edge.
- Word mapping: word index i, channel k = i/3.
  - i%3 = 0 → value[31:0]
  - i%3 = 1 → value[63:32]
  - i%3 = 2 → count
  - Words 0..WPP-2 go into shadow registers.
- State RECV:
  - tready = NOT(idx == WPP-1 AND out_valid AND NOT out_ready). tready is combinational on out_ready; this is the only backpressure point.
  - Accepted beat, idx < WPP-1, tlast=0: store to shadow, idx++.
  - Accepted beat, idx < WPP-1, tlast=1: discard packet, idx ← 0, err_short pulses the next cycle, stay in RECV.
  - Accepted beat, idx = WPP-1, tlast=1 (commit):
    - out_val/out_cnt ← shadow plus the final word.
    - out_valid ← 1, pkt_count++, idx ← 0.
    - All of these take effect at the same edge, so latency from the final beat to out_valid is 1 cycle.
  - Accepted beat, idx = WPP-1, tlast=0: discard packet, err_long pulses, idx ← 0, go to DRAIN.
- State DRAIN:
  - tready = 1; accepted beats are dropped.
  - The accepted beat with tlast=1 → RECV, idx ← 0.
  - No further error pulses while draining.
- Output handshake:
  - out_valid && out_ready at an edge → out_valid ← 0.
  - A commit in the same cycle keeps out_valid = 1 with the new data; the commit wins.
  - out_val and out_cnt change only on commit and are stable while out_valid = 1 and not consumed.
- err_count: increments on each err_short or err_long and saturates at 2^ERR_W-1.
- Reset mid-packet: the partial packet is discarded, and the next packet's word 0 is expected first.
- tvalid gaps: allowed at any position; the index holds.

Decomposition:
- Package vna_stream_pkg holds:
  - WORDS_PER_CH = 3
  - Word offsets W_VAL_LO = 0, W_VAL_HI = 1, W_CNT = 2
  - Stream data width 32
  - The packetiser transmitter shares this package.
- No sub-module: a single FSM with a word-index counter and shadow registers is sufficient.

Test Plan:
- Nominal packet: send 12 beats, continuous tvalid, out_ready = 1, with val_1 = 0x0000000100000002, cnt_1 = 3 … cnt_4 = 12, tlast on beat 11. Required: out_valid rises 1 cycle after beat 11; out_val[63:0] = 0x0000000100000002; out_cnt[127:96] = 12; pkt_count = 1.
- Backpressure: out_ready = 0, send two packets back-to-back. Required: tready drops at beat 11 of the second packet. Then raise out_ready: the second commit occurs in the same cycle as the first consume, out_valid stays 1 with the new data, and pkt_count = 2.
- Short packet: tlast on beat 5. Required: err_short pulse, err_count = 1, outputs unchanged. The next full packet then commits correctly.
- Long packet: 15 beats with tlast only on beat 14. Required: err_long pulse at beat 11, beats 12–14 dropped, then return to RECV. The following good packet commits.
- Random tvalid gaps (50%): a good packet still commits with correct data.
- Reset during beat 7: tready = 0 and all outputs = 0 during reset. After release, a new 12-beat packet commits.
